// File: rtl/vector_register_file_if.sv
// Port bundle for vector_register_file: two read ports, masked write port,
// the clear request and the sequencer status.
interface vector_register_file_if #(
  parameter int LANE_W = 8,
  parameter int LANES  = 16,
  parameter int ADDR_W = 5
);
  localparam int VW = LANES * LANE_W;

  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [ADDR_W-1:0] A3;
  logic [VW-1:0]     WD3;
  logic              WE3;
  logic [LANES-1:0]  WM3;
  logic              CLR;
  logic [VW-1:0]     RD1;
  logic [VW-1:0]     RD2;
  logic              BUSY;
  logic              clr_state;  // debug view of the clear FSM: 1 = CLEAR

  // Write handshake: WE3 is valid and !BUSY is ready. A write transfers on a
  // rising edge where both hold and A3 decodes to a vector register; a write
  // offered while BUSY is high is dropped, not stalled. CLR has no ready: it is
  // only sampled while the sequencer is idle.
  modport master (
    output A1, A2, A3, WD3, WE3, WM3, CLR,
    input  RD1, RD2, BUSY, clr_state
  );

  modport slave (
    input  A1, A2, A3, WD3, WE3, WM3, CLR,
    output RD1, RD2, BUSY, clr_state
  );
endinterface

// File: rtl/vector_register_file.sv
// Lane-masked vector register file with a hardware clear sweep.
// Define VRF_BYPASS_EN to forward accepted write lanes onto the read ports.
module vector_register_file #(
  parameter int LANE_W  = 8,
  parameter int LANES   = 16,
  parameter int N_VREGS = 16,
  parameter int ADDR_W  = 5
) (
  input logic                   clk,
  input logic                   rst,
  vector_register_file_if.slave bus
);
  localparam int VW    = LANES * LANE_W;
  localparam int IDX_W = ADDR_W - 1;
  localparam int CNT_W = $clog2(N_VREGS) + 1;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             busy;

  logic [LANE_W-1:0] mem [N_VREGS][LANES];

  logic [IDX_W-1:0] idx1;
  logic [IDX_W-1:0] idx2;
  logic [IDX_W-1:0] idx3;
  logic             valid1;
  logic             valid2;
  logic             valid3;
  logic             wr_accept;
  logic [VW-1:0]    rd1;
  logic [VW-1:0]    rd2;

  // Upper half of the shared address space, and only indices that exist.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    logic [31:0] idx;
    idx = 32'(a[IDX_W-1:0]);
    return a[ADDR_W-1] && (idx < 32'(N_VREGS));
  endfunction

  assign idx1   = bus.A1[IDX_W-1:0];
  assign idx2   = bus.A2[IDX_W-1:0];
  assign idx3   = bus.A3[IDX_W-1:0];
  assign valid1 = addr_valid(bus.A1);
  assign valid2 = addr_valid(bus.A2);
  assign valid3 = addr_valid(bus.A3);

  assign busy      = (state == CLEAR);
  assign wr_accept = bus.WE3 && !busy && valid3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The CLR edge only arms the sweep; clearing starts on the following edge.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.CLR) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        if (cnt == CNT_W'(N_VREGS - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // A sweep clear and an accepted write never meet: writes need !busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N_VREGS; r++) begin
        for (int l = 0; l < LANES; l++) begin
          mem[r][l] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < N_VREGS; r++) begin
        for (int l = 0; l < LANES; l++) begin
          if (busy && (cnt == CNT_W'(r))) begin
            mem[r][l] <= '0;
          end else if (wr_accept && (idx3 == IDX_W'(r)) && bus.WM3[l]) begin
            mem[r][l] <= bus.WD3[l*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int r = 0; r < N_VREGS; r++) begin
      for (int l = 0; l < LANES; l++) begin
        if (valid1 && (idx1 == IDX_W'(r))) begin
          rd1[l*LANE_W +: LANE_W] = mem[r][l];
        end
        if (valid2 && (idx2 == IDX_W'(r))) begin
          rd2[l*LANE_W +: LANE_W] = mem[r][l];
        end
      end
    end
`ifdef VRF_BYPASS_EN
    // Address equality with an accepted (hence valid) A3 implies a valid read.
    for (int l = 0; l < LANES; l++) begin
      if (wr_accept && bus.WM3[l]) begin
        if (bus.A1 == bus.A3) begin
          rd1[l*LANE_W +: LANE_W] = bus.WD3[l*LANE_W +: LANE_W];
        end
        if (bus.A2 == bus.A3) begin
          rd2[l*LANE_W +: LANE_W] = bus.WD3[l*LANE_W +: LANE_W];
        end
      end
    end
`endif
  end

  assign bus.RD1       = rd1;
  assign bus.RD2       = rd2;
  assign bus.BUSY      = busy;
  assign bus.clr_state = busy;
endmodule
